zone_decoder_seq: RTL and testbench
===================================

Name: zone_decoder_seq

Overview:
- Parametrised registered N-to-2^N zone decoder for the smart-home controller.
- Drives a one-hot or thermometer ("less-or-equal") enable vector to actuator/zone lines.
- Index comes from a host `sel_valid`/`sel` load, or from a built-in scan sequencer that steps through every zone with a programmable dwell time.
- Generalises the fixed 4-to-16 combinational decoder: width, output mode and sequencing are all configurable.

Parameters:
- SEL_W, 4, index width; OUT_W = 2**SEL_W output lines (derived localparam, not overridable).
- DWELL, 4, clock cycles each index is held during scan; legal range ≥1.
- SCAN_LOOP, 0, 1 = scan restarts at index 0 after the last index; 0 = scan ends and returns to IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  output enable; 0 forces `out` to all zeros, state and `cur_sel` unaffected.
- mode_therm  in  1  0 = one-hot output, 1 = thermometer output.
- sel_valid  in  1  load request for `sel`; honoured only in IDLE.
- sel  in  SEL_W  index to load.
- scan_start  in  1  start-scan pulse; honoured only in IDLE.
- scan_stop  in  1  abort-scan pulse; honoured only in SCAN.
- out  out  OUT_W  registered decoded vector.
- cur_sel  out  SEL_W  registered current index.
- scanning  out  1  high while FSM is in SCAN.
- scan_done  out  1  one-cycle pulse at scan completion.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, cur_sel=0, dwell counter=0, out=0, scanning=0, scan_done=0.
  - Leaving reset: out stays 0 until the first edge with en=1, then reflects cur_sel=0.
- Output decode (registered; `out` is computed from the next-state index, so it changes on the same edge as `cur_sel`):
  - en=0: out=0.
  - mode_therm=0: out[i]=1 only for i==cur_sel.
  - mode_therm=1: out[i]=1 for all i≤cur_sel.
  - Changes on mode_therm or en appear on `out` at the next edge.
- IDLE:
  - sel_valid=1: cur_sel<=sel, out updated at that edge; 1-cycle latency from sel_valid to out.
  - scan_start=1: cur_sel<=0, dwell counter<=0, state<=SCAN, scanning<=1.
  - scan_start and sel_valid in the same cycle: scan_start wins, sel is ignored.
  - scan_stop is ignored.
- SCAN:
  - Dwell counter increments each cycle.
  - When counter==DWELL-1: counter<=0 and cur_sel advances by 1. Each index is therefore held exactly DWELL cycles; DWELL=1 advances every cycle.
  - Last index (OUT_W-1) expiring: cur_sel<=0 (wrap) and scan_done pulses for 1 cycle.
    - SCAN_LOOP=1: remain in SCAN.
    - SCAN_LOOP=0: go to IDLE, scanning<=0, cur_sel<=0.
  - sel_valid and scan_start are ignored.
  - scan_stop: state<=IDLE next edge, cur_sel held, no scan_done.
  - scan_stop in the same cycle as dwell expiry: stop wins, no increment, no scan_done.
- scan_done is never asserted outside the wrap event.
- Reset asserted mid-scan: immediate return to reset values, no scan_done.
- Index arithmetic is modulo 2**SEL_W; no out-of-range index exists.

Optional Feature:
- Macro: ZONE_DECODER_SKIP_MASK_EN.
- Defined:
  - Adds input `skip_mask [OUT_W-1:0]`, sampled every cycle.
  - Scan visits only indices with skip_mask[i]=0. scan_start jumps to the lowest unmasked index. Each advance goes to the next higher unmasked index.
  - After the highest unmasked index expires: wrap/scan_done as above, with the wrap target being the lowest unmasked index.
  - All indices masked at scan_start: no SCAN entry; scan_done pulses next cycle, cur_sel unchanged.
  - Direct loads via sel_valid ignore the mask.
- Undefined: the port does not exist and every index is scanned.

Test Plan:
- Reset and direct load:
  - Apply rst_n=0 mid-operation → out=0, cur_sel=0 immediately.
  - Release reset, en=1, sel_valid with sel=5, mode_therm=0 → next edge out=16'h0020, cur_sel=5.
- Thermometer mode: sel=5, mode_therm=1 → out=16'h003F. Then en=0 → out=16'h0000 while cur_sel stays 5.
- Full scan:
  - scan_start with DWELL=4, SCAN_LOOP=0 → each index 0..15 held 4 cycles.
  - scan_done single pulse 64 cycles after start; then scanning=0, cur_sel=0.
  - sel_valid during scan ignored.
- Scan stop and conflicts:
  - scan_stop in the cycle where index 7 dwell expires → IDLE, cur_sel=7, no scan_done.
  - scan_start together with sel_valid(sel=9) in IDLE → scan wins, cur_sel=0.
- Loop mode: SCAN_LOOP=1, DWELL=1 → cur_sel 0..15,0,1…; scan_done pulses every 16 cycles; scanning stays 1.
- Skip mask (macro defined): skip_mask=16'hFFF0 → scan visits only 0..3, scan_done after 16 cycles (DWELL=4). skip_mask=16'hFFFF → scan_done next cycle, never enters SCAN.

Source files
------------

// File: rtl/zone_decoder_seq.sv
// Registered N-to-2^N zone decoder (one-hot or thermometer) with host load and a dwell-timed scan sequencer.
// Optional ZONE_DECODER_SKIP_MASK_EN adds a skip_mask input that removes zones from the scan.
module zone_decoder_seq #(
  parameter int SEL_W = 4,
  parameter int DWELL = 4,
  parameter int SCAN_LOOP = 0,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode_therm,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             scan_start,
  input  logic             scan_stop,
`ifdef ZONE_DECODER_SKIP_MASK_EN
  input  logic [OUT_W-1:0] skip_mask,
`endif
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             scanning,
  output logic             scan_done
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SEL_W-1:0]   sel_n;
  logic [OUT_W-1:0]   out_n;
  logic               done_n;
  logic [OUT_W-1:0]   mask;
  logic [SEL_W:0]     first, nxt;

`ifdef ZONE_DECODER_SKIP_MASK_EN
  assign mask = skip_mask;
`else
  assign mask = '0;
`endif

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx, input logic therm);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < OUT_W; i++)
      v[i] = therm ? (i <= int'(idx)) : (i == int'(idx));
    return v;
  endfunction

  // {found, index} of the lowest zone not skipped
  function automatic logic [SEL_W:0] first_free(input logic [OUT_W-1:0] m);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = OUT_W - 1; i >= 0; i--)
      if (!m[i]) r = {1'b1, SEL_W'(i)};
    return r;
  endfunction

  // {found, index} of the lowest unskipped zone strictly above idx
  function automatic logic [SEL_W:0] next_free(input logic [OUT_W-1:0] m, input logic [SEL_W-1:0] idx);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = OUT_W - 1; i >= 0; i--)
      if (!m[i] && (i > int'(idx))) r = {1'b1, SEL_W'(i)};
    return r;
  endfunction

  always_comb begin
    state_n = state;
    sel_n   = cur_sel;
    cnt_n   = cnt;
    done_n  = 1'b0;
    first   = first_free(mask);
    nxt     = next_free(mask, cur_sel);
    case (state)
      IDLE: begin
        if (scan_start) begin
          if (first[SEL_W]) begin
            state_n = SCAN;
            sel_n   = first[SEL_W-1:0];
            cnt_n   = '0;
          end else begin
            done_n = 1'b1;
          end
        end else if (sel_valid) begin
          sel_n = sel;
        end
      end
      SCAN: begin
        if (scan_stop) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (nxt[SEL_W]) begin
            sel_n = nxt[SEL_W-1:0];
          end else begin
            done_n = 1'b1;
            if (SCAN_LOOP != 0) begin
              sel_n = first[SEL_W-1:0];
            end else begin
              state_n = IDLE;
              sel_n   = '0;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // decode from the next index so out and cur_sel move on the same edge
    out_n = en ? decode(sel_n, mode_therm) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_sel   <= '0;
      cnt       <= '0;
      out       <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_n;
      cur_sel   <= sel_n;
      cnt       <= cnt_n;
      out       <= out_n;
      scan_done <= done_n;
    end
  end

  assign scanning = (state == SCAN);

endmodule

// File: tb/tb_zone_decoder_seq.sv
// Self-checking bench for zone_decoder_seq: instance a (DWELL=4, one-shot) and instance b (DWELL=1, looping).
// Exercises ZONE_DECODER_SKIP_MASK_EN scenarios when that macro is defined.
module tb_zone_decoder_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mode_therm = 1'b0;
  logic        sel_valid = 1'b0;
  logic [3:0]  sel = '0;
  logic        scan_start = 1'b0;
  logic        scan_stop = 1'b0;
`ifdef ZONE_DECODER_SKIP_MASK_EN
  logic [15:0] skip_mask = '0;
`endif

  logic [15:0] out_a, out_b;
  logic [3:0]  cur_a, cur_b;
  logic        scanning_a, scanning_b, done_a, done_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  zone_decoder_seq #(.SEL_W(4), .DWELL(4), .SCAN_LOOP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_therm(mode_therm),
    .sel_valid(sel_valid), .sel(sel), .scan_start(scan_start), .scan_stop(scan_stop),
`ifdef ZONE_DECODER_SKIP_MASK_EN
    .skip_mask(skip_mask),
`endif
    .out(out_a), .cur_sel(cur_a), .scanning(scanning_a), .scan_done(done_a)
  );

  zone_decoder_seq #(.SEL_W(4), .DWELL(1), .SCAN_LOOP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_therm(mode_therm),
    .sel_valid(sel_valid), .sel(sel), .scan_start(scan_start), .scan_stop(scan_stop),
`ifdef ZONE_DECODER_SKIP_MASK_EN
    .skip_mask(skip_mask),
`endif
    .out(out_b), .cur_sel(cur_b), .scanning(scanning_b), .scan_done(done_b)
  );

  // reference decode: one-hot is a shifted 1, thermometer is 2^(idx+1)-1
  function automatic logic [15:0] ref_out(input int idx, input logic therm, input logic e);
    if (!e) return 16'h0000;
    if (therm) return 16'((32'd2 << idx) - 32'd1);
    return 16'(32'd1 << idx);
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; scan_start = 1'b0; scan_stop = 1'b0; sel_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [21:0] got;
    rst_n = 1'b0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {out_a, cur_a, scanning_a, done_a};
    vectors++;
    if (got !== 22'h0) begin miscompares++; $display("FAIL reset_state got=%h exp=%h", got, 22'h0); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_a !== 16'h0) begin miscompares++; $display("FAIL en_low_after_reset got=%h exp=0000", out_a); end
    end
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({out_a, cur_a} !== {16'h0001, 4'h0}) begin
      miscompares++; $display("FAIL first_en got=%h exp=%h", {out_a, cur_a}, {16'h0001, 4'h0});
    end
    @(negedge clk); sel_valid = 1'b1; sel = 4'd11;
    @(negedge clk); sel_valid = 1'b0; scan_start = 1'b1;
    @(negedge clk); scan_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    got = {out_a, cur_a, scanning_a, done_a};
    vectors++;
    if (got !== 22'h0) begin miscompares++; $display("FAIL async_reset got=%h exp=%h", got, 22'h0); end
    @(posedge clk); #1;
    got = {out_a, cur_a, scanning_a, done_a};
    vectors++;
    if (got !== 22'h0) begin miscompares++; $display("FAIL reset_held got=%h exp=%h", got, 22'h0); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load();
    logic [19:0] got, expv;
    logic [3:0]  exp_sel, s;
    logic        sv, m, e;
    @(negedge clk); en = 1'b1; mode_therm = 1'b0; sel_valid = 1'b1; sel = 4'd5;
    @(posedge clk); #1;
    vectors++;
    if ({out_a, cur_a} !== {16'h0020, 4'd5}) begin
      miscompares++; $display("FAIL load_onehot got=%h exp=%h", {out_a, cur_a}, {16'h0020, 4'd5});
    end
    @(negedge clk); sel_valid = 1'b0; mode_therm = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({out_a, cur_a} !== {16'h003F, 4'd5}) begin
      miscompares++; $display("FAIL load_therm got=%h exp=%h", {out_a, cur_a}, {16'h003F, 4'd5});
    end
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({out_a, cur_a} !== {16'h0000, 4'd5}) begin
      miscompares++; $display("FAIL en_off got=%h exp=%h", {out_a, cur_a}, {16'h0000, 4'd5});
    end
    exp_sel = 4'd5;
    for (int i = 0; i < 24; i++) begin
      sv = 1'($urandom % 2); s = 4'($urandom); m = 1'($urandom % 2); e = (($urandom % 4) != 0);
      @(negedge clk); sel_valid = sv; sel = s; mode_therm = m; en = e;
      @(posedge clk); #1;
      if (sv) exp_sel = s;
      got = {out_a, cur_a};
      expv = {ref_out(int'(exp_sel), m, e), exp_sel};
      vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL load_rand i=%0d got=%h exp=%h", i, got, expv); end
    end
    @(negedge clk); sel_valid = 1'b0; en = 1'b1; mode_therm = 1'b0;
  endtask

  task automatic test_full_scan();
    logic [21:0] got, expv;
    int ec;
    logic es, ed;
    @(negedge clk); sel_valid = 1'b1; sel = 4'd3;
    @(negedge clk); sel_valid = 1'b0; scan_start = 1'b1;
    @(posedge clk); #1;
    got = {out_a, cur_a, scanning_a, done_a};
    expv = {ref_out(0, mode_therm, 1'b1), 4'd0, 1'b1, 1'b0};
    vectors++;
    if (got !== expv) begin miscompares++; $display("FAIL scan_entry got=%h exp=%h", got, expv); end
    for (int t = 1; t <= 65; t++) begin
      @(negedge clk);
      scan_start = 1'b0;
      sel_valid = (t <= 64) ? 1'($urandom % 2) : 1'b0;
      sel = 4'($urandom);
      mode_therm = 1'($urandom % 2);
      @(posedge clk); #1;
      if (t < 64) begin ec = t / 4; es = 1'b1; ed = 1'b0; end
      else begin ec = 0; es = 1'b0; ed = (t == 64); end
      got = {out_a, cur_a, scanning_a, done_a};
      expv = {ref_out(ec, mode_therm, 1'b1), 4'(ec), es, ed};
      vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL full_scan t=%0d got=%h exp=%h", t, got, expv); end
    end
    @(negedge clk); mode_therm = 1'b0;
  endtask

  task automatic test_stop();
    logic [5:0] got, expv;
    int stops[6];
    @(negedge clk); sel_valid = 1'b1; sel = 4'd10;
    @(negedge clk); sel_valid = 1'b0; scan_stop = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({cur_a, scanning_a, done_a} !== {4'd10, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL stop_in_idle got=%h exp=%h", {cur_a, scanning_a, done_a}, {4'd10, 2'b00});
    end
    stops[0] = 32; stops[1] = 64;
    for (int k = 2; k < 6; k++) stops[k] = 1 + int'($urandom % 63);
    foreach (stops[k]) begin
      @(negedge clk); scan_stop = 1'b0; scan_start = 1'b1;
      @(negedge clk); scan_start = 1'b0;
      for (int t = 1; t < stops[k]; t++) @(negedge clk);
      scan_stop = 1'b1;
      @(posedge clk); #1;
      got = {cur_a, scanning_a, done_a};
      expv = {4'((stops[k] - 1) / 4), 1'b0, 1'b0};
      vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL stop p=%0d got=%h exp=%h", stops[k], got, expv); end
      @(negedge clk); scan_stop = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({cur_a, scanning_a, done_a} !== expv) begin
        miscompares++; $display("FAIL stop_hold p=%0d got=%h exp=%h", stops[k], {cur_a, scanning_a, done_a}, expv);
      end
    end
  endtask

  task automatic test_conflict();
    @(negedge clk); sel_valid = 1'b1; sel = 4'd3;
    @(negedge clk); sel = 4'd9; scan_start = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({cur_a, scanning_a} !== {4'd0, 1'b1}) begin
      miscompares++; $display("FAIL start_vs_load got=%h exp=%h", {cur_a, scanning_a}, {4'd0, 1'b1});
    end
    @(negedge clk); scan_start = 1'b0; sel_valid = 1'b0;
    repeat (4) @(negedge clk);
    scan_start = 1'b1; sel_valid = 1'b1; sel = 4'd12;
    @(posedge clk); #1;
    vectors++;
    if ({cur_a, scanning_a} !== {4'd1, 1'b1}) begin
      miscompares++; $display("FAIL restart_in_scan got=%h exp=%h", {cur_a, scanning_a}, {4'd1, 1'b1});
    end
    @(negedge clk); scan_start = 1'b0; sel_valid = 1'b0; scan_stop = 1'b1;
    @(negedge clk); scan_stop = 1'b0;
  endtask

  task automatic test_loop();
    logic [21:0] got, expv;
    pulse_reset();
`ifdef ZONE_DECODER_SKIP_MASK_EN
    skip_mask = '0;
`endif
    en = 1'b1;
    @(negedge clk); scan_start = 1'b1;
    for (int t = 0; t <= 40; t++) begin
      if (t == 1) begin @(negedge clk); scan_start = 1'b0; mode_therm = 1'($urandom % 2); end
      else if (t > 1) begin @(negedge clk); mode_therm = 1'($urandom % 2); end
      @(posedge clk); #1;
      got = {out_b, cur_b, scanning_b, done_b};
      expv = {ref_out(t % 16, mode_therm, 1'b1), 4'(t % 16), 1'b1, (t > 0) && (t % 16 == 0)};
      vectors++;
      if (got !== expv) begin miscompares++; $display("FAIL loop t=%0d got=%h exp=%h", t, got, expv); end
    end
    @(negedge clk); scan_stop = 1'b1; mode_therm = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({cur_b, scanning_b, done_b, cur_a, scanning_a} !== {4'd8, 2'b00, 4'd10, 1'b0}) begin
      miscompares++;
      $display("FAIL loop_stop got=%h exp=%h", {cur_b, scanning_b, done_b, cur_a, scanning_a}, {4'd8, 2'b00, 4'd10, 1'b0});
    end
    @(negedge clk); scan_stop = 1'b0;
  endtask

`ifdef ZONE_DECODER_SKIP_MASK_EN
  task automatic test_skip();
    logic [5:0]  got, expv;
    logic [15:0] masks[4];
    int          visit[$];
    int          n, ec;
    pulse_reset();
    en = 1'b1;
    masks[0] = 16'hFFF0;
    for (int k = 1; k < 4; k++) begin
      masks[k] = 16'($urandom);
      masks[k][$urandom % 16] = 1'b0;
    end
    foreach (masks[k]) begin
      visit.delete();
      for (int i = 0; i < 16; i++) if (!masks[k][i]) visit.push_back(i);
      n = visit.size();
      @(negedge clk); skip_mask = masks[k]; sel_valid = 1'b1; sel = 4'd15;
      @(negedge clk); sel_valid = 1'b0; scan_start = 1'b1;
      for (int t = 0; t <= 4 * n + 1; t++) begin
        if (t > 0) begin @(negedge clk); scan_start = 1'b0; end
        @(posedge clk); #1;
        ec = (t < 4 * n) ? visit[t / 4] : 0;
        expv = {4'(ec), t < 4 * n, t == 4 * n};
        got = {cur_a, scanning_a, done_a};
        vectors++;
        if (got !== expv) begin
          miscompares++; $display("FAIL skip mask=%h t=%0d got=%h exp=%h", masks[k], t, got, expv);
        end
      end
    end
    @(negedge clk); skip_mask = 16'hFFFF; sel_valid = 1'b1; sel = 4'd6;
    @(posedge clk); #1;
    vectors++;
    if (cur_a !== 4'd6) begin miscompares++; $display("FAIL load_ignores_mask got=%h exp=6", cur_a); end
    @(negedge clk); sel_valid = 1'b0; scan_start = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({cur_a, scanning_a, done_a} !== {4'd6, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL all_masked got=%h exp=%h", {cur_a, scanning_a, done_a}, {4'd6, 2'b01});
    end
    @(negedge clk); scan_start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({cur_a, scanning_a, done_a} !== {4'd6, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL all_masked_after got=%h exp=%h", {cur_a, scanning_a, done_a}, {4'd6, 2'b00});
    end
    @(negedge clk); skip_mask = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_full_scan();
    test_stop();
    test_conflict();
    test_loop();
`ifdef ZONE_DECODER_SKIP_MASK_EN
    test_skip();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
